// File: rtl/proj_pkg.sv
// Shared types and constants for the kmer feeder: base codes, FSM states and
// the per-index hash seed generator.
package proj_pkg;

    localparam int unsigned MAX_SEEDS = 8;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    typedef enum logic {
        StFill,
        StEmit
    } state_e;

    // Golden-ratio stride keeps successive seeds well spread.
    function automatic logic [31:0] seed_of(input logic [$clog2(MAX_SEEDS)-1:0] idx);
        return 32'(idx) * 32'h9E37_79B9;
    endfunction

endpackage

// File: rtl/kmer_window.sv
// Sliding window of K bases with fill counter; build with KMER_CANONICAL_EN to
// present min(forward, reverse-complement) instead of the forward window.
module kmer_window
    import proj_pkg::*;
#(
    parameter int unsigned K = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift,
    input  logic           clear,
    input  logic [1:0]     base,
    output logic [2*K-1:0] window,
    output logic           full
);

    localparam int unsigned CntW = $clog2(K + 1);

    logic [2*K-1:0] fwd_d, fwd_q;
    logic [CntW-1:0] cnt_d, cnt_q;

    // Counter saturates at K; full means the next accepted base completes a window.
    assign full = (cnt_q >= CntW'(K - 1));

    always_comb begin
        fwd_d = fwd_q;
        cnt_d = cnt_q;
        if (shift) begin
            fwd_d = {fwd_q[2*K-3:0], base};
            if (clear) begin
                cnt_d = '0;
            end else if (cnt_q != CntW'(K)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
            cnt_q <= '0;
        end else begin
            fwd_q <= fwd_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef KMER_CANONICAL_EN
    logic [2*K-1:0] rc_d, rc_q;

    always_comb begin
        rc_d = rc_q;
        if (shift) begin
            rc_d = {~base, rc_q[2*K-1:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    // Window reflects the incoming base so the top can latch it on the same edge.
    assign window = (fwd_d < rc_d) ? fwd_d : rc_d;
`else
    assign window = fwd_d;
`endif

endmodule

// File: rtl/kmer_feeder.sv
// Streams 2-bit bases into a K-base window and emits NUM_SEEDS (seed, kmer)
// pairs per complete window. KMER_CANONICAL_EN selects canonical kmers.
module kmer_feeder
    import proj_pkg::*;
#(
    parameter int unsigned HASHER_DATA_BITS = 32,
    parameter int unsigned NUM_SEEDS        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         base_valid,
    output logic                         base_ready,
    input  logic [1:0]                   base_data,
    input  logic                         base_last,
    output logic                         kmer_valid,
    input  logic                         kmer_ready,
    output logic [HASHER_DATA_BITS-1:0]  kmer,
    output logic [HASHER_DATA_BITS-1:0]  seed,
    output logic [$clog2(MAX_SEEDS)-1:0] seed_idx,
    output logic                         kmer_last,
    output logic                         seq_short
);

    localparam int unsigned K    = HASHER_DATA_BITS / 2;
    localparam int unsigned IdxW = $clog2(MAX_SEEDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SEEDS - 1);

    state_e                state_d, state_q;
    logic                  base_ready_d, base_ready_q;
    logic                  kmer_valid_d, kmer_valid_q;
    logic [2*K-1:0]        kmer_d, kmer_q;
    logic [HASHER_DATA_BITS-1:0] seed_d, seed_q;
    logic [IdxW-1:0]       seed_idx_d, seed_idx_q;
    logic                  kmer_last_d, kmer_last_q;
    logic                  seq_short_d, seq_short_q;
    logic                  last_d, last_q;

    logic                  base_acc;
    logic                  kmer_acc;
    logic [2*K-1:0]        window;
    logic                  win_full;

    assign base_acc = base_valid && base_ready_q;
    assign kmer_acc = kmer_valid_q && kmer_ready;

    kmer_window #(
        .K(K)
    ) u_window (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (base_acc),
        .clear (base_last),
        .base  (base_data),
        .window(window),
        .full  (win_full)
    );

    always_comb begin
        state_d     = state_q;
        kmer_d      = kmer_q;
        seed_d      = seed_q;
        seed_idx_d  = seed_idx_q;
        kmer_last_d = kmer_last_q;
        last_d      = last_q;
        seq_short_d = 1'b0;
        unique case (state_q)
            StFill: begin
                if (base_acc) begin
                    if (win_full) begin
                        state_d     = StEmit;
                        kmer_d      = window;
                        seed_idx_d  = '0;
                        seed_d      = HASHER_DATA_BITS'(seed_of('0));
                        last_d      = base_last;
                        kmer_last_d = base_last && (LastIdx == '0);
                    end else if (base_last) begin
                        seq_short_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (kmer_acc) begin
                    if (seed_idx_q == LastIdx) begin
                        state_d     = StFill;
                        seed_idx_d  = '0;
                        seed_d      = HASHER_DATA_BITS'(seed_of('0));
                        kmer_last_d = 1'b0;
                    end else begin
                        seed_idx_d  = seed_idx_q + 1'b1;
                        seed_d      = HASHER_DATA_BITS'(seed_of(seed_idx_d));
                        kmer_last_d = last_q && (seed_idx_d == LastIdx);
                    end
                end
            end
            default: state_d = StFill;
        endcase
        base_ready_d = (state_d == StFill);
        kmer_valid_d = (state_d == StEmit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFill;
            base_ready_q <= 1'b0;
            kmer_valid_q <= 1'b0;
            kmer_q       <= '0;
            seed_q       <= '0;
            seed_idx_q   <= '0;
            kmer_last_q  <= 1'b0;
            seq_short_q  <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_ready_q <= base_ready_d;
            kmer_valid_q <= kmer_valid_d;
            kmer_q       <= kmer_d;
            seed_q       <= seed_d;
            seed_idx_q   <= seed_idx_d;
            kmer_last_q  <= kmer_last_d;
            seq_short_q  <= seq_short_d;
            last_q       <= last_d;
        end
    end

    assign base_ready = base_ready_q;
    assign kmer_valid = kmer_valid_q;
    assign kmer       = kmer_q;
    assign seed       = seed_q;
    assign seed_idx   = seed_idx_q;
    assign kmer_last  = kmer_last_q;
    assign seq_short  = seq_short_q;

endmodule

// File: tb/tb_kmer_feeder.sv
// Scoreboard bench for kmer_feeder: expected pairs are queued as bases are sent
// and checked by a monitor as each pair transfers.
module tb_kmer_feeder;
    import proj_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        base_valid = 1'b0;
    logic        base_ready;
    logic [1:0]  base_data = 2'b00;
    logic        base_last = 1'b0;
    logic        kmer_valid;
    logic        kmer_ready = 1'b1;
    logic [31:0] kmer;
    logic [31:0] seed;
    logic [2:0]  seed_idx;
    logic        kmer_last;
    logic        seq_short;

    kmer_feeder #(
        .HASHER_DATA_BITS(32),
        .NUM_SEEDS       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_valid(base_valid),
        .base_ready(base_ready),
        .base_data (base_data),
        .base_last (base_last),
        .kmer_valid(kmer_valid),
        .kmer_ready(kmer_ready),
        .kmer      (kmer),
        .seed      (seed),
        .seed_idx  (seed_idx),
        .kmer_last (kmer_last),
        .seq_short (seq_short)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] kmer;
        logic [31:0] seed;
        logic [2:0]  idx;
        logic        last;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    int    short_cnt = 0;
    int    cyc = 0;
    int    acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_seed(input int i);
        case (i)
            0:       return 32'h0000_0000;
            1:       return 32'h9E37_79B9;
            2:       return 32'h3C6E_F372;
            default: return 32'hDAA6_6D2B;
        endcase
    endfunction

    // Monitor: every transfer pops one expected pair.
    always @(negedge clk) begin
        if (rst_n && seq_short) short_cnt++;
        if (rst_n && kmer_valid && kmer_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pair: got kmer=%h idx=%0d, required no pair",
                         kmer, seed_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if ({kmer, seed, seed_idx, kmer_last} !== mon_e) begin
                    n_fail++;
                    $display("FAIL pair: got kmer=%h seed=%h idx=%0d last=%b, required kmer=%h seed=%h idx=%0d last=%b",
                             kmer, seed, seed_idx, kmer_last,
                             mon_e.kmer, mon_e.seed, mon_e.idx, mon_e.last);
                end
            end
        end
    end

    task automatic push_kmer(input logic [31:0] k, input logic last);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{kmer: k, seed: exp_seed(i), idx: 3'(i), last: last && (i == 3)});
        end
    endtask

    task automatic send_base(input logic [1:0] b, input logic last);
        base_data  = b;
        base_last  = last;
        base_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (base_ready) begin
                @(posedge clk);
                #1;
                acc_cyc    = cyc;
                base_valid = 1'b0;
                base_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL base_accept_timeout: got base_ready=0, required 1");
        base_valid = 1'b0;
        base_last  = 1'b0;
    endtask

    task automatic send_run(input logic [1:0] b, input int n);
        for (int i = 0; i < n; i++) send_base(b, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !kmer_valid) begin
                n_checks++;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_drain: got %0d pairs pending, required 0", name, exp_q.size());
    endtask

    task automatic wait_idx(input logic [2:0] idx);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (kmer_valid && seed_idx == idx) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idx: got no pair with idx=%0d, required one", idx);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({base_ready, kmer_valid, kmer, seed, seed_idx, kmer_last, seq_short} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b kmer=%h seed=%h idx=%0d, required all 0",
                     base_ready, kmer_valid, kmer, seed, seed_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({base_ready, kmer_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b, required rdy=1 vld=0",
                     base_ready, kmer_valid);
        end
    endtask

    task automatic test_all_a();
        send_run(BASE_A, 15);
        push_kmer(32'h0000_0000, 1'b1);
        send_base(BASE_A, 1'b1);
        wait_drain("all_a");
    endtask

    task automatic test_acgt();
        int t16;
        for (int r = 0; r < 4; r++) begin
            send_base(BASE_A, 1'b0);
            send_base(BASE_C, 1'b0);
            send_base(BASE_G, 1'b0);
            if (r == 3) push_kmer(32'h1B1B_1B1B, 1'b0);
            send_base(BASE_T, 1'b0);
        end
        t16 = acc_cyc;
        push_kmer(32'h6C6C_6C6C, 1'b1);
        send_base(BASE_A, 1'b1);
        n_checks++;
        if (acc_cyc - t16 != 5) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles between bases, required 5", acc_cyc - t16);
        end
        wait_drain("acgt");
    endtask

    task automatic test_all_t();
        send_run(BASE_T, 15);
`ifdef KMER_CANONICAL_EN
        push_kmer(32'h0000_0000, 1'b1);
`else
        push_kmer(32'hFFFF_FFFF, 1'b1);
`endif
        send_base(BASE_T, 1'b1);
        wait_drain("all_t");
    endtask

    task automatic test_short();
        int s0;
        s0 = short_cnt;
        send_run(BASE_C, 4);
        send_base(BASE_C, 1'b1);
        n_checks++;
        if (seq_short !== 1'b1) begin
            n_fail++;
            $display("FAIL short_pulse: got seq_short=%b, required 1", seq_short);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (short_cnt - s0 != 1 || kmer_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_once: got %0d pulses vld=%b, required 1 pulse vld=0",
                     short_cnt - s0, kmer_valid);
        end
        send_run(BASE_C, 15);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (kmer_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_refill: got kmer_valid=%b after 15 bases, required 0", kmer_valid);
        end
        push_kmer(32'h5555_5555, 1'b1);
        send_base(BASE_C, 1'b1);
        wait_drain("short");
    endtask

    task automatic test_stall();
        send_run(BASE_A, 15);
        push_kmer(32'h0000_0001, 1'b1);
        send_base(BASE_C, 1'b1);
        wait_idx(3'd1);
        kmer_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({kmer_valid, base_ready, kmer, seed, seed_idx, kmer_last} !==
                {1'b1, 1'b0, 32'h0000_0001, 32'h9E37_79B9, 3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold: got vld=%b rdy=%b kmer=%h seed=%h idx=%0d last=%b, required 1 0 00000001 9e3779b9 1 0",
                         kmer_valid, base_ready, kmer, seed, seed_idx, kmer_last);
            end
        end
        kmer_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_reset_mid_emit();
        send_run(BASE_C, 15);
        push_kmer(32'h5555_5555, 1'b1);
        send_base(BASE_C, 1'b1);
        wait_idx(3'd2);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({base_ready, kmer_valid, kmer, seed, seed_idx, kmer_last, seq_short} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got vld=%b kmer=%h seed=%h idx=%0d, required all 0",
                     kmer_valid, kmer, seed, seed_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (base_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got base_ready=%b, required 1", base_ready);
        end
        for (int r = 0; r < 4; r++) begin
            send_base(BASE_A, 1'b0);
            send_base(BASE_C, 1'b0);
            send_base(BASE_G, 1'b0);
            if (r == 3) begin
                n_checks++;
                if (kmer_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_reset_refill: got kmer_valid=%b after 15 bases, required 0",
                             kmer_valid);
                end
                push_kmer(32'h1B1B_1B1B, 1'b1);
                send_base(BASE_T, 1'b1);
            end else begin
                send_base(BASE_T, 1'b0);
            end
        end
        wait_drain("mid_reset");
    endtask

    initial begin
        test_reset();
        test_all_a();
        test_acgt();
        test_all_t();
        test_short();
        test_stall();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kmer_feeder.md
# kmer_feeder

Streaming front end for the MinHash datapath. It accepts a 2-bit-encoded DNA base stream, maintains a sliding window of K = HASHER_DATA_BITS/2 bases, and, for every complete window, presents NUM_SEEDS (seed, kmer) pairs over a valid/ready handshake. Its output drives the seed/kmer inputs of the murmur_4bytes hashers. Downstream min-tracking logic uses the per-pair index and last flag.

## Interface
- HASHER_DATA_BITS, 32, kmer/seed word width; K = HASHER_DATA_BITS/2 bases per window.
- NUM_SEEDS, 4, hash seeds applied per kmer, 1..MAX_SEEDS.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- base_valid  input  1  base_data/base_last valid.
- base_ready  output  1  feeder accepts a base this cycle.
- base_data  input  2  base code: A=00, C=01, G=10, T=11.
- base_last  input  1  final base of the current sequence.
- kmer_valid  output  1  kmer/seed/seed_idx/kmer_last valid.
- kmer_ready  input  1  downstream accepts the pair.
- kmer  output  HASHER_DATA_BITS  packed window; oldest base in MSBs.
- seed  output  HASHER_DATA_BITS  seed for this pair.
- seed_idx  output  $clog2(MAX_SEEDS)  index 0..NUM_SEEDS-1 of the seed.
- kmer_last  output  1  last pair of the last kmer of a sequence.
- seq_short  output  1  one-cycle pulse: sequence ended with fewer than K bases.

## Operation
- Base transfer on base_valid && base_ready; kmer transfer on kmer_valid && kmer_ready.
- Window: fwd <= {fwd[2K-3:0], base_data}. Fill counter increments per accepted base, saturates at K, clears after an accepted base_last.
- State FILL: base_ready=1, kmer_valid=0. The accepted base that brings the count to K (count was K-1 or K) latches the new window into kmer, sets seed_idx=0, and goes to EMIT. The base_last flag is latched with it.
- State EMIT: base_ready=0, kmer_valid=1. On each transfer seed_idx increments and seed updates. A transfer at seed_idx=NUM_SEEDS-1 returns to FILL.
- seed = seed_of(seed_idx), a package function: i*0x9E3779B9 mod 2^32. Seeds 0..3 are 0x00000000, 0x9E3779B9, 0x3C6EF372, 0xDAA66D2B.
- kmer_last=1 only on the pair with seed_idx=NUM_SEEDS-1 of a window whose completing base had base_last=1.
- base_last accepted with count+1 < K: no EMIT, seq_short pulses the next cycle, counter clears, state stays FILL.
- Accepted base_last always starts a fresh sequence: the next base begins a new window at count 1.
- Reset, including mid-EMIT: state FILL, counter 0, fwd/rc 0, any in-flight pairs dropped.

## Timing
- Reset values: base_ready 0 while rst_n low, 1 in the first cycle after release. kmer_valid, kmer, seed, seed_idx, kmer_last and seq_short are all 0.
- Latency: kmer_valid rises the cycle after the completing base is accepted.
- Outputs are registered and held stable while kmer_valid && !kmer_ready.
- kmer_valid never drops without a transfer.
- Steady-state throughput: one base per NUM_SEEDS+1 cycles with kmer_ready held high.
- base_ready is a function of state only, not of kmer_ready. There is no combinational path from input to output.

## Configuration
- KMER_CANONICAL_EN defined: keep a reverse-complement register, rc <= {~base_data, rc[2K-1:2]}. The latched kmer is min(fwd, rc), unsigned.
- KMER_CANONICAL_EN undefined: no rc register; kmer = fwd.
- Handshake and timing are identical in both builds.

## Structure
- The proj_pkg package holds:
  - MAX_SEEDS = 8
  - the base-code localparams
  - the state enum (FILL, EMIT)
  - function seed_of.
- Sub-module kmer_window holds the fwd/rc shift registers, the fill counter and the canonical select. It exposes window, full and the clear input.
- The top level holds the FSM, the output registers and the seed index.

## Test plan
- 16× A, base_last on the 16th → 4 pairs with kmer=0x00000000 and seeds 0x00000000/0x9E3779B9/0x3C6EF372/0xDAA66D2B, seed_idx 0..3; kmer_last only on idx 3.
- ACGT×4, then A, base_last on A → kmer 0x1B1B1B1B (4 pairs), then 0x6C6C6C6C (4 pairs, last flagged).
- 16× T → kmer 0xFFFFFFFF without KMER_CANONICAL_EN; 0x00000000 with it.
- 5 bases, base_last on 5th → no kmer_valid, seq_short pulses once. The following 16 bases yield the first kmer only after the 16th.
- kmer_ready low 3 cycles at seed_idx=1 → all outputs stable, base_ready=0; resumes at idx 1 with no pair lost or duplicated.
- rst_n low during EMIT at seed_idx=2 → outputs 0 immediately. After release base_ready=1, and a full 16-base window is required before the next kmer.
